// File: rtl/serial_ripple_borrow_sub.sv
// Slice-serial ripple-borrow subtractor: d = a - b - bi (mod 2^N), W bits per clock.
// Define SERIAL_RIPPLE_BORROW_SUB_OVERFLOW_EN to add the signed-overflow output ov.
module serial_ripple_borrow_sub #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bo,
`ifdef SERIAL_RIPPLE_BORROW_SUB_OVERFLOW_EN
    output logic         ov,
`endif
    output logic         busy
);

    localparam int S  = (W > 0) ? (N / W) : 1;
    localparam int CW = (S > 1) ? $clog2(S) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(S - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if ((W < 1) || ((N % W) != 0)) begin : g_bad_cfg
        $error("serial_ripple_borrow_sub: N must be a positive multiple of W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [CW-1:0] cnt_r;
    logic          borrow_r;

    int            slice_lsb_s;
    logic [W-1:0]  slice_a_s;
    logic [W-1:0]  slice_b_s;
    logic [W-1:0]  diff_s;
    logic          borrow_next_s;
    logic          msb_borrow_in_s;

    // One W-bit slice of the ripple-borrow chain, selected by the slice counter.
    always_comb begin
        slice_lsb_s = int'(cnt_r) * W;
        slice_a_s   = a_r[slice_lsb_s +: W];
        slice_b_s   = b_r[slice_lsb_s +: W];
        {borrow_next_s, diff_s} = {1'b0, slice_a_s} - {1'b0, slice_b_s} - {{W{1'b0}}, borrow_r};
        // Borrow entering the slice MSB recovered from the MSB sum bit.
        msb_borrow_in_s = slice_a_s[W-1] ^ slice_b_s[W-1] ^ diff_s[W-1];
    end

    // Control FSM, operand capture and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            d         <= {N{1'b0}};
            bo        <= 1'b0;
            busy      <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            borrow_r  <= 1'b0;
            a_r       <= {N{1'b0}};
            b_r       <= {N{1'b0}};
`ifdef SERIAL_RIPPLE_BORROW_SUB_OVERFLOW_EN
            ov        <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_ready && in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        borrow_r <= bi;
                        cnt_r    <= {CW{1'b0}};
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= BUSY;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    d[slice_lsb_s +: W] <= diff_s;
                    borrow_r            <= borrow_next_s;
                    if (cnt_r == CNT_LAST) begin
                        bo        <= borrow_next_s;
`ifdef SERIAL_RIPPLE_BORROW_SUB_OVERFLOW_EN
                        ov        <= msb_borrow_in_s ^ borrow_next_s;
`endif
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        cnt_r     <= {CW{1'b0}};
                        state_r   <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    cnt_r     <= {CW{1'b0}};
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifndef SERIAL_RIPPLE_BORROW_SUB_OVERFLOW_EN
    logic unused_s;
    // Overflow tap is only consumed when the overflow output exists.
    always_comb begin
        unused_s = msb_borrow_in_s;
    end
`endif

endmodule

// File: tb/tb_serial_ripple_borrow_sub.sv
// Directed self-checking bench for serial_ripple_borrow_sub (N=32, W=8).
module tb_serial_ripple_borrow_sub;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        bo;
    logic        busy;
`ifdef SERIAL_RIPPLE_BORROW_SUB_OVERFLOW_EN
    logic        ov;
`endif

    int tests = 0;
    int fails = 0;

    serial_ripple_borrow_sub #(.N(32), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bo        (bo),
`ifdef SERIAL_RIPPLE_BORROW_SUB_OVERFLOW_EN
        .ov        (ov),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_in_ready_timeout"}, 64'(in_ready), 64'd1);
    endtask

    task automatic wait_out(input string tag, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tbi, input logic [31:0] ed, input logic ebo, input logic eov);
        int lat;
        a = ta; b = tb; bi = tbi; out_ready = 1'b1; in_valid = 1'b1;
        wait_in_ready(tag);
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_out(tag, lat);
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_d"}, 64'(d), 64'(ed));
        check({tag, "_bo"}, 64'(bo), 64'(ebo));
`ifdef SERIAL_RIPPLE_BORROW_SUB_OVERFLOW_EN
        check({tag, "_ov"}, 64'(ov), 64'(eov));
`else
        if (eov === 1'bx) $display("unused overflow expectation");
`endif
        tick();
        check({tag, "_post_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_post_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        logic [33:0] exp_q[$];
        logic [33:0] e;
        logic [32:0] full;
        logic        acc;
        int cyc, last_acc, n_acc, n_out;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'h0; b = 32'h0; bi = 1'b0;
        #3;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_d", 64'(d), 64'd0);
        check("rst_bo", 64'(bo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        #9 rst_n = 1'b1;
        tick();
        check("rel_in_ready", 64'(in_ready), 64'd1);

        run_op("basic",  32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        run_op("ripple", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("bi_ov",  32'h8000_0000, 32'h0000_0000, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op("equal",  32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0);

        // Backpressure: result held in DONE while new operands come and go.
        a = 32'h1234_5678; b = 32'h0000_1111; bi = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        wait_in_ready("bp");
        tick();
        wait_out("bp", lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            a = 32'hDEAD_0000 + 32'(i);
            b = 32'h0000_0100 + 32'(i);
            bi = 1'(i);
            tick();
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_d", 64'(d), 64'h1234_4567);
            check("bp_bo", 64'(bo), 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        a = 32'h0000_0100; b = 32'h0000_0001; bi = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        wait_out("bp_next", lat);
        check("bp_next_d", 64'(d), 64'h0000_00FF);
        check("bp_next_bo", 64'(bo), 64'd0);
        tick();

        // Reset during the second BUSY cycle.
        a = 32'h0000_0005; b = 32'h0000_0003; bi = 1'b0; in_valid = 1'b1;
        wait_in_ready("mid");
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_d", 64'(d), 64'd0);
        check("mid_rst_bo", 64'(bo), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        #2 rst_n = 1'b1;
        run_op("after_rst", 32'h0000_0010, 32'h0000_0010, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Streaming with random operands against a 33-bit reference subtract.
        cyc = 0; last_acc = -1; n_acc = 0; n_out = 0;
        a = $urandom; b = $urandom; bi = 1'($urandom_range(1));
        out_ready = 1'b1;
        while (n_out < 100 && cyc < 1000) begin
            in_valid = (n_acc < 100);
            acc = in_ready && in_valid;
            if (acc) begin
                full = {1'b0, a} - {1'b0, b} - {32'd0, bi};
                e = {((a[31] != b[31]) && (full[31] != a[31])), full};
                exp_q.push_back(e);
            end
            tick();
            cyc++;
            if (acc) begin
                if (last_acc >= 0) check("stream_interval", 64'(cyc - last_acc), 64'd6);
                last_acc = cyc;
                n_acc++;
                a = $urandom; b = $urandom; bi = 1'($urandom_range(1));
            end
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
                check("stream_d", 64'(d), 64'(e[31:0]));
                check("stream_bo", 64'(bo), 64'(e[32]));
`ifdef SERIAL_RIPPLE_BORROW_SUB_OVERFLOW_EN
                check("stream_ov", 64'(ov), 64'(e[33]));
`endif
                n_out++;
            end
        end
        in_valid = 1'b0;
        check("stream_count", 64'(n_out), 64'd100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_ripple_borrow_sub.md
Name: serial_ripple_borrow_sub

Overview:
- Multi-cycle, slice-serial ripple-borrow subtractor. It is the inverse operation of the FixedPointArithmetic ripple-carry adder.
- Computes d = (a - b - bi) mod 2^N and borrow-out bo, processing W bits per clock.
- Used in the FixedPointArithmetic Sub unit where area matters more than throughput.
- Valid/ready on both input and output; one operation in flight.

Parameters:
- N, 32, datapath width in bits. N must be a multiple of W; otherwise elaboration fails via $error.
- W, 8, slice width in bits processed per BUSY cycle. S = N/W slices.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  N  minuend, unsigned or two's complement.
- b  input  N  subtrahend.
- bi  input  1  borrow in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- d  output  N  difference.
- bo  output  1  borrow out; 1 iff a < b + bi (unsigned).
- busy  output  1  state != IDLE.

Behaviour:
- Reset: clk single clock; rst_n asynchronous, active-low.
  - While rst_n=0: state=IDLE, in_ready=0, out_valid=0, d=0, bo=0, busy=0, slice counter=0, internal borrow=0.
  - First clock edge after release: in_ready=1.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. If in_valid=1 at the edge, capture a, b, bi, set counter=0, borrow=bi, go to BUSY.
  - BUSY: in_ready=0. Each edge computes slice k = counter:
    - {borrow_next, d[k*W +: W]} = a[k*W +: W] - b[k*W +: W] - borrow.
    - Store d[k*W +: W], borrow <= borrow_next, counter <= counter+1.
    - After slice S-1: bo <= final borrow, go to DONE.
  - DONE: out_valid=1. d and bo are held stable. If out_ready=1 at the edge, go to IDLE.
- Latency: out_valid rises S cycles after the accept edge (4 for defaults).
- Throughput: one operation per S+2 cycles; there is no overlap of DONE and accept.
- in_ready is registered and is 0 in BUSY and DONE. in_valid in those states is ignored; the operand source holds until accepted.
- d shows partial results while BUSY. The value is only meaningful while out_valid=1.
- Borrow wraps across slice boundaries exactly as a full N-bit ripple-borrow: d equals a - b - bi for all 2^(2N+1) inputs.
- Counter is ceil(log2(S)) bits, minimum 1. It never exceeds S-1.
- Asserting rst_n mid-BUSY or mid-DONE aborts the operation. No output is produced for the aborted operands.
- out_ready=1 in IDLE or BUSY has no effect.

Optional Feature:
- Macro: SERIAL_RIPPLE_BORROW_SUB_OVERFLOW_EN.
- When defined:
  - Extra output port ov (1 bit) gives signed two's-complement overflow.
  - ov = borrow into bit N-1 XOR borrow out of bit N-1, captured during the final slice.
  - ov is valid with out_valid and resets to 0.
- When undefined:
  - Port ov is absent and no overflow logic is built.
  - All other behaviour is identical.

Test Plan:
- Basic subtract: a=0x0000_0005, b=0x0000_0003, bi=0, accept at edge T, out_ready=1.
  - Required: out_valid at T+4, d=0x0000_0002, bo=0, IDLE and in_ready=1 one cycle after the handshake.
- Full borrow ripple: a=0x0000_0000, b=0x0000_0001, bi=0.
  - Required: d=0xFFFF_FFFF, bo=1; the borrow crosses all 4 slice boundaries.
- Borrow-in and overflow: a=0x8000_0000, b=0x0000_0000, bi=1.
  - Required: d=0x7FFF_FFFF, bo=0, and ov=1 when the macro is defined.
  - Also a=0x7FFF_FFFF, b=0x7FFF_FFFF, bi=0. Required: d=0, bo=0, ov=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid with new operands.
  - Required: d, bo and out_valid stable, in_ready=0, new operands not captured.
  - Release out_ready: handshake completes, and the next accept takes the operands then present.
- Reset mid-operation: pull rst_n low during the second BUSY cycle.
  - Required: immediate out_valid=0, d=0, bo=0, busy=0.
  - After release, a=0x10, b=0x10, bi=1 gives d=0xFFFF_FFFF, bo=1.
- Streaming: in_valid and out_ready held high, with 100 random operand pairs.
  - Required: an accept every 6 cycles (S+2), and every d and bo matches the reference model (a - b - bi).
